// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch resolution for BEQ/BNE.
// Holds the front end while a branch source register is still being produced
// upstream, then redirects the PC and squashes IF/ID when the branch is taken.
// It also keeps wrapping counts of resolved and taken branches.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   hold_i                          global freeze; state held, stall_o forced high
//   id_op/id_rs/id_rt/id_imm/id_pc4 fields of the instruction in ID
//   br_taken                        comparator result for the ID instruction
//   ex_regwrite/ex_memread/ex_rd    EX-stage producer information
//   mem_memread/mem_rd              MEM-stage load information
//   stall_o/bubble_o                hold PC + IF/ID, insert NOP into ID/EX
//   pc_sel/pc_target/ifid_flush     redirect controls (combinational)
//   br_total_cnt/br_taken_cnt       branch statistics
module branch_resolve_ctrl #(
    parameter int unsigned CNT_W  = 16,
    parameter logic [5:0]  OP_BEQ = 6'h04,
    parameter logic [5:0]  OP_BNE = 6'h05
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [15:0]      id_imm,
    input  logic [31:0]      id_pc4,
    input  logic             br_taken,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_memread,
    input  logic [4:0]       mem_rd,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] br_total_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
);

    localparam int unsigned STALL_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [STALL_W-1:0] cnt;
    logic [STALL_W-1:0] cnt_nxt;
    logic [STALL_W-1:0] need;
    logic               is_br;
    logic               ex_hit;
    logic               mem_hit;
    logic               resolve;

    // Register r feeds one of the branch operands (r0 never creates a hazard).
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] a,
                                       input logic [4:0] b);
        return (r != 5'd0) && ((r == a) || (r == b));
    endfunction

    assign is_br   = (id_op == OP_BEQ) || (id_op == OP_BNE);
    assign ex_hit  = reg_match(ex_rd, id_rs, id_rt);
    assign mem_hit = reg_match(mem_rd, id_rs, id_rt);

    // Cycles to wait before operands are final; earlier rules take priority.
    always_comb begin
        need = STALL_W'(0);
        if (ex_memread && ex_hit) begin
            need = STALL_W'(2);
        end else if (ex_regwrite && ex_hit) begin
            need = STALL_W'(1);
        end else if (mem_memread && mem_hit) begin
            need = STALL_W'(1);
        end
    end

    // Branch target: PC+4 plus sign-extended word offset, wraps mod 2^32.
    assign pc_target = id_pc4 + {{14{id_imm[15]}}, id_imm, 2'b00};

    // State register; everything freezes while hold_i is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= STALL_W'(0);
        end else if (!hold_i) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state. cnt holds the number of STALL cycles still to be spent.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (is_br && (need != STALL_W'(0))) begin
                    cnt_nxt   = need - STALL_W'(1);
                    state_nxt = (need == STALL_W'(2)) ? STALL : RESOLVE;
                end
            end
            STALL: begin
                // Hazard inputs are ignored here; only the count matters.
                if (cnt <= STALL_W'(1)) begin
                    cnt_nxt   = STALL_W'(0);
                    state_nxt = RESOLVE;
                end else begin
                    cnt_nxt = cnt - STALL_W'(1);
                end
            end
            RESOLVE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs; hold_i forces stall and suppresses every other action.
    always_comb begin
        stall_o    = 1'b0;
        bubble_o   = 1'b0;
        resolve    = 1'b0;
        pc_sel     = 1'b0;
        ifid_flush = 1'b0;
        case (state)
            IDLE: begin
                if (is_br && (need != STALL_W'(0))) begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                end else if (is_br) begin
                    resolve = 1'b1;
                end
            end
            STALL: begin
                stall_o  = 1'b1;
                bubble_o = 1'b1;
            end
            RESOLVE: resolve = 1'b1;
            default: ;
        endcase
        if (hold_i) begin
            stall_o  = 1'b1;
            bubble_o = 1'b0;
            resolve  = 1'b0;
        end
        pc_sel     = resolve && br_taken;
        ifid_flush = resolve && br_taken;
    end

    // Branch statistics, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_cnt <= CNT_W'(0);
            br_taken_cnt <= CNT_W'(0);
        end else if (resolve) begin
            br_total_cnt <= br_total_cnt + CNT_W'(1);
            if (br_taken) begin
                br_taken_cnt <= br_taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a default-width instance and a
// 4-bit-counter instance share all inputs; expected outputs are queued when a
// step is driven and popped when the outputs are sampled.
module tb_branch_resolve_ctrl;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    logic        clk;
    logic        rst_n;
    logic        hold_i;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [15:0] id_imm;
    logic [31:0] id_pc4;
    logic        br_taken;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_memread;
    logic [4:0]  mem_rd;

    logic        stall_o, bubble_o, pc_sel, ifid_flush;
    logic [31:0] pc_target;
    logic [15:0] br_total_cnt, br_taken_cnt;

    logic        stall4, bubble4, pc_sel4, flush4;
    logic [31:0] target4;
    logic [3:0]  total4, taken4;

    branch_resolve_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold_i),
        .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm), .id_pc4(id_pc4),
        .br_taken(br_taken), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .stall_o(stall_o), .bubble_o(bubble_o), .pc_sel(pc_sel), .pc_target(pc_target),
        .ifid_flush(ifid_flush), .br_total_cnt(br_total_cnt), .br_taken_cnt(br_taken_cnt)
    );

    branch_resolve_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .hold_i(hold_i),
        .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm), .id_pc4(id_pc4),
        .br_taken(br_taken), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .stall_o(stall4), .bubble_o(bubble4), .pc_sel(pc_sel4), .pc_target(target4),
        .ifid_flush(flush4), .br_total_cnt(total4), .br_taken_cnt(taken4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        bubble;
        logic        pcsel;
        logic        flush;
        logic [31:0] target;
        logic [15:0] total;
        logic [15:0] taken;
        logic [3:0]  total4;
        logic [3:0]  taken4;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] m_total = 16'd0;
    logic [15:0] m_taken = 16'd0;
    logic [3:0]  m_total4 = 4'd0;
    logic [3:0]  m_taken4 = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_total  = 16'd0;
        m_taken  = 16'd0;
        m_total4 = 4'd0;
        m_taken4 = 4'd0;
    endtask

    task automatic idle_in();
        hold_i = 1'b0; id_op = 6'h00; id_rs = 5'd0; id_rt = 5'd0;
        id_imm = 16'h0000; id_pc4 = 32'h0; br_taken = 1'b0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        mem_memread = 1'b0; mem_rd = 5'd0;
    endtask

    // One clock: expected stall/bubble and whether this cycle resolves.
    task automatic cyc(input string tag, input logic s, input logic b, input logic r);
        exp_t e;
        exp_t g;
        e.stall  = s;
        e.bubble = b;
        e.pcsel  = r & br_taken;
        e.flush  = r & br_taken;
        e.target = id_pc4 + {{14{id_imm[15]}}, id_imm, 2'b00};
        e.total  = m_total;
        e.taken  = m_taken;
        e.total4 = m_total4;
        e.taken4 = m_taken4;
        sbq.push_back(e);
        #2;
        g = sbq.pop_front();
        chk({tag, ".stall"},  32'(stall_o),    32'(g.stall));
        chk({tag, ".bubble"}, 32'(bubble_o),   32'(g.bubble));
        chk({tag, ".pc_sel"}, 32'(pc_sel),     32'(g.pcsel));
        chk({tag, ".flush"},  32'(ifid_flush), 32'(g.flush));
        chk({tag, ".target"}, pc_target,       g.target);
        chk({tag, ".total"},  32'(br_total_cnt), 32'(g.total));
        chk({tag, ".taken"},  32'(br_taken_cnt), 32'(g.taken));
        chk({tag, ".total4"}, 32'(total4),     32'(g.total4));
        chk({tag, ".taken4"}, 32'(taken4),     32'(g.taken4));
        chk({tag, ".pc_sel4"}, 32'(pc_sel4),   32'(g.pcsel));
        if (r) begin
            m_total  = m_total + 16'd1;
            m_total4 = m_total4 + 4'd1;
            if (br_taken) begin
                m_taken  = m_taken + 16'd1;
                m_taken4 = m_taken4 + 4'd1;
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        #1;
        cyc("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc("post_reset", 1'b0, 1'b0, 1'b0);

        // No hazard, taken: redirect in the same cycle.
        id_op = OP_BEQ; id_pc4 = 32'h0040_0010; id_imm = 16'h0003; br_taken = 1'b1;
        cyc("nohaz", 1'b0, 1'b0, 1'b1);
        chk("nohaz.target_const", pc_target, 32'h0040_001C);
        chk("nohaz.total_const", 32'(br_total_cnt), 32'd1);
        chk("nohaz.taken_const", 32'(br_taken_cnt), 32'd1);

        // Negative offset, not taken.
        idle_in();
        id_op = OP_BNE; id_pc4 = 32'h0000_0008; id_imm = 16'hFFFE;
        cyc("negoff", 1'b0, 1'b0, 1'b1);
        chk("negoff.target_const", pc_target, 32'h0000_0000);
        chk("negoff.taken_const", 32'(br_taken_cnt), 32'd1);

        // Load in EX feeding rs: two stall cycles, resolve on the third.
        idle_in();
        id_op = OP_BEQ; id_rs = 5'd5; id_pc4 = 32'h0000_1000; id_imm = 16'h0010;
        br_taken = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
        cyc("ldu.c0", 1'b1, 1'b1, 1'b0);
        cyc("ldu.c1", 1'b1, 1'b1, 1'b0);
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
        cyc("ldu.c2", 1'b0, 1'b0, 1'b1);
        idle_in();
        cyc("ldu.after", 1'b0, 1'b0, 1'b0);

        // ALU producer in EX matching rt: one stall cycle.
        id_op = OP_BNE; id_rs = 5'd7; id_rt = 5'd3; id_pc4 = 32'h0000_2000;
        id_imm = 16'h8000; ex_regwrite = 1'b1; ex_rd = 5'd3;
        cyc("alu.c0", 1'b1, 1'b1, 1'b0);
        cyc("alu.c1", 1'b0, 1'b0, 1'b1);
        // Same, but producer targets r0: no hazard.
        id_rt = 5'd0; ex_rd = 5'd0; br_taken = 1'b1;
        cyc("alu.r0", 1'b0, 1'b0, 1'b1);

        // Load in MEM matching rs: one stall cycle; a load in EX elsewhere is ignored.
        idle_in();
        id_op = OP_BEQ; id_rs = 5'd9; id_rt = 5'd4; id_pc4 = 32'h1234_5678;
        id_imm = 16'h7FFF; mem_memread = 1'b1; mem_rd = 5'd9;
        ex_memread = 1'b1; ex_rd = 5'd12; br_taken = 1'b1;
        cyc("memld.c0", 1'b1, 1'b1, 1'b0);
        cyc("memld.c1", 1'b0, 1'b0, 1'b1);

        // Freeze for three cycles in the middle of a load-use stall.
        idle_in();
        id_op = OP_BEQ; id_rt = 5'd6; id_pc4 = 32'h0000_4000; id_imm = 16'h0004;
        br_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd6;
        cyc("hold.c0", 1'b1, 1'b1, 1'b0);
        hold_i = 1'b1; ex_memread = 1'b0; ex_rd = 5'd0;
        for (int i = 0; i < 3; i++) cyc("hold.frz", 1'b1, 1'b0, 1'b0);
        hold_i = 1'b0;
        cyc("hold.rel", 1'b1, 1'b1, 1'b0);
        cyc("hold.res", 1'b0, 1'b0, 1'b1);

        // Freeze on a hazard-free branch defers the resolve.
        id_op = OP_BNE; id_pc4 = 32'h0000_5000; id_imm = 16'hFFFF; br_taken = 1'b1;
        hold_i = 1'b1;
        cyc("hold.idle", 1'b1, 1'b0, 1'b0);
        hold_i = 1'b0;
        cyc("hold.idle_rel", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a stall abandons the branch.
        idle_in();
        id_op = OP_BEQ; id_rs = 5'd2; br_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd2;
        cyc("rst.c0", 1'b1, 1'b1, 1'b0);
        idle_in();
        rst_n = 1'b0;
        model_reset();
        cyc("rst.low", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc("rst.rel", 1'b0, 1'b0, 1'b0);

        // Sixteen resolutions: the 4-bit counter wraps to zero.
        id_op = OP_BEQ; id_pc4 = 32'h0000_0100;
        for (int i = 0; i < 16; i++) begin
            id_imm   = 16'(i);
            br_taken = (i % 3) == 0;
            cyc("wrap", 1'b0, 1'b0, 1'b1);
        end
        idle_in();
        cyc("wrap.after", 1'b0, 1'b0, 1'b0);
        chk("wrap.total4_const", 32'(total4), 32'd0);
        chk("wrap.total16_const", 32'(br_total_cnt), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
